if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_pkg.sv | 29 ++
 rtl/if_fetch_unit_fetch_fifo.sv | 64 ++++++
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bubble encoding,
// FSM states and the fetch-queue entry layout.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef SYS_ADDR_SPACE
`define SYS_ADDR_SPACE 32
`endif

package if_fetch_unit_pkg;

  localparam int unsigned ADDR_W = `SYS_ADDR_SPACE;
  localparam int unsigned INST_W = `INST_WIDTH;

  // addi x0, x0, 0 presented while the queue is empty
  localparam logic [INST_W-1:0] NOP_INSTR = INST_W'(32'h0000_0013);
  localparam logic [ADDR_W-1:0] BUBBLE_PC = '0;

  typedef enum logic {
    RESET_IDLE = 1'b0,
    RUN        = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Circular fetch queue of {pc, instr} entries with occupancy count.
// Push and pop may coincide, even when full; flush empties the queue.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == FULL);
  assign empty   = (count == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are meaningless outside the valid window
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, tracks each
// request's PC in order, queues returned instructions and drops
// responses that belong to fetches abandoned by a redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [`SYS_ADDR_SPACE-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned                FQ_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  mode_i,
  input  logic                        redirect_i,
  input  logic [`SYS_ADDR_SPACE-1:0]  redirect_pc_i,
  output logic                        imem_req_o,
  output logic [`SYS_ADDR_SPACE-1:0]  imem_addr_o,
  input  logic                        imem_gnt_i,
  input  logic                        imem_rvalid_i,
  input  logic [`INST_WIDTH-1:0]      imem_rdata_i,
  output logic [`INST_WIDTH-1:0]      instr_o,
  output logic [`SYS_ADDR_SPACE-1:0]  pc_o
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned TW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FQ_DEPTH);
  localparam logic [TW-1:0] TAG_LAST = TW'(FQ_DEPTH - 1);

  fetch_state_e         state;
  fetch_state_e         state_next;
  logic [ADDR_W-1:0]    fetch_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        outstanding_next;
  logic [CW-1:0]        discard_cnt;
  logic [CW-1:0]        fq_count;
  logic [ADDR_W-1:0]    tag_pc [FQ_DEPTH];
  logic [TW-1:0]        tag_wr;
  logic [TW-1:0]        tag_rd;
  logic                 can_issue;
  logic                 granted;
  logic                 accepted;
  logic                 resp;
  logic                 keep;
  logic                 pop;
  logic                 fq_empty;
  fetch_entry_t         head;
  fetch_entry_t         push_entry;
  logic [2:0]           ignored_unused;

  function automatic logic [TW-1:0] bump(input logic [TW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + 1'b1;
  endfunction

  // Flush hint is handled upstream; low redirect bits are discarded
  assign ignored_unused = {mode_i[0], redirect_pc_i[1:0]};

  // Lifecycle state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RESET_IDLE;
    else       state <= state_next;
  end

  // Next state and issue eligibility (counts as of the start of the cycle)
  always_comb begin
    state_next = state;
    can_issue  = 1'b0;
    case (state)
      RESET_IDLE: state_next = RUN;
      RUN:        can_issue  = ({1'b0, fq_count} + {1'b0, outstanding}) < DEPTH_W;
      default:    state_next = RESET_IDLE;
    endcase
  end

  assign imem_req_o  = can_issue && !redirect_i;
  assign imem_addr_o = {fetch_pc[ADDR_W-1:2], 2'b00};
  // A grant landing on a redirect still occupies a memory slot
  assign granted     = can_issue && imem_gnt_i;
  assign accepted    = imem_req_o && imem_gnt_i;
  assign resp        = imem_rvalid_i && (outstanding != '0);
  assign keep        = resp && (discard_cnt == '0) && !redirect_i;
  assign pop         = !fq_empty && !mode_i[1] && !redirect_i;
  assign push_entry  = '{pc: tag_pc[tag_rd], instr: imem_rdata_i};

  // In-flight request count after this cycle's grant and response
  always_comb begin
    outstanding_next = outstanding;
    if (granted && !resp)      outstanding_next = outstanding + 1'b1;
    else if (!granted && resp) outstanding_next = outstanding - 1'b1;
  end

  // Fetch PC, request accounting and post-redirect discard tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (redirect_i)    fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
      else if (accepted) fetch_pc <= fetch_pc + `SYS_ADDR_SPACE'(4);
      outstanding <= outstanding_next;
      // Every request still in flight after a redirect is stale
      if (redirect_i)                       discard_cnt <= outstanding_next;
      else if (resp && discard_cnt != '0)   discard_cnt <= discard_cnt - 1'b1;
      if (granted) tag_wr <= bump(tag_wr);
      if (resp)    tag_rd <= bump(tag_rd);
    end
  end

  // Per-request PC tags, consumed in order by responses
  always_ff @(posedge clk_i) begin
    if (granted) tag_pc[tag_wr] <= imem_addr_o;
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (redirect_i),
    .push  (keep),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .count (fq_count),
    .empty (fq_empty)
  );

  assign instr_o = fq_empty ? NOP_INSTR : head.instr;
  assign pc_o    = fq_empty ? BUBBLE_PC : head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus queues expected grant
// addresses and expected delivered instructions; independent monitors
// compare them as the DUT grants and delivers.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;

  logic        gnt_en;
  logic        resp_en;

  logic [31:0] exp_addr [$];
  logic [63:0] exp_out  [$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mode_i        (mode),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr),
    .pc_o          (pc)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Memory model: in-order responses, one cycle after grant when enabled
  initial begin : memory
    logic [31:0] pend [$];
    logic        g;
    logic        r;
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      g = imem_req & imem_gnt;
      a = imem_addr;
      r = rst;
      @(posedge clk);
      #1;
      if (r) begin
        pend.delete();
        imem_rvalid = 1'b0;
      end else begin
        if (g) pend.push_back(a);
        if (resp_en && pend.size() > 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_data(pend.pop_front());
        end else begin
          imem_rvalid = 1'b0;
        end
      end
    end
  end

  // Grant monitor: every accepted request must match the next expected address
  initial begin : addr_mon
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_addr: got unexpected grant at %h, required none", imem_addr);
        end else begin
          check("grant_addr", {32'h0, imem_addr}, {32'h0, exp_addr.pop_front()});
        end
      end
    end
  end

  // Delivery monitor: a non-bubble head consumed this cycle must match
  initial begin : out_mon
    forever begin
      @(negedge clk);
      if (!rst && !mode[1] && !redirect && !(instr == NOP && pc == 32'h0)) begin
        if (exp_out.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL deliver: got unexpected pc %h instr %h, required none", pc, instr);
        end else begin
          check("deliver", {pc, instr}, exp_out.pop_front());
        end
      end
    end
  end

  task automatic issue(input int unsigned n);
    int unsigned got = 0;
    int unsigned k = 0;
    @(posedge clk);
    #1;
    gnt_en = 1'b1;
    while (got < n && k < 100) begin
      @(negedge clk);
      k++;
      if (imem_req && imem_gnt) got++;
    end
    @(posedge clk);
    #1;
    gnt_en = 1'b0;
    check("issue_grants", 64'(got), 64'(n));
  endtask

  task automatic drain();
    int unsigned k = 0;
    while ((exp_out.size() != 0 || exp_addr.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(exp_out.size() + exp_addr.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    check("redirect_req_low", 64'(imem_req), 64'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; mode = 2'b00; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b0; resp_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_instr", 64'(instr), 64'(NOP));
    check("rst_pc", 64'(pc), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    check("run_req", 64'(imem_req), 64'd1);
    check("run_addr", 64'(imem_addr), 64'd0);

    // Zero-wait streaming from reset PC
    for (int unsigned i = 0; i < 8; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_out.push_back({32'(i * 4), mem_data(32'(i * 4))});
    end
    issue(8);
    drain();

    // Stall with a full queue
    mode = 2'b10;
    exp_addr.push_back(32'h20);
    exp_addr.push_back(32'h24);
    issue(2);
    gnt_en = 1'b1;
    repeat (3) @(posedge clk);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", 64'(imem_req), 64'd0);
      check("stall_instr", 64'(instr), 64'(mem_data(32'h20)));
      check("stall_pc", 64'(pc), 64'h20);
    end
    @(posedge clk); #1;
    gnt_en = 1'b0;
    mode = 2'b00;
    exp_out.push_back({32'h20, mem_data(32'h20)});
    exp_out.push_back({32'h24, mem_data(32'h24)});
    drain();

    // Unaligned redirect target, then redirect with two fetches in flight
    do_redirect(32'h0000_0103 & 32'h0000_0013 | 32'h0000_0013);
    @(negedge clk);
    check("align_addr", 64'(imem_addr), 64'h10);
    check("align_req", 64'(imem_req), 64'd1);
    resp_en = 1'b0;
    exp_addr.push_back(32'h10);
    exp_addr.push_back(32'h14);
    issue(2);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    check("redir_req_low", 64'(imem_req), 64'd0);
    resp_en = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bubble_instr", 64'(instr), 64'(NOP));
      check("bubble_pc", 64'(pc), 64'd0);
    end
    check("redir_addr", 64'(imem_addr), 64'h200);
    exp_addr.push_back(32'h200);
    exp_out.push_back({32'h200, mem_data(32'h200)});
    issue(1);
    drain();

    // Address wrap at the top of the space
    do_redirect(32'hFFFF_FFFC);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    exp_out.push_back({32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC)});
    exp_out.push_back({32'h0000_0000, mem_data(32'h0000_0000)});
    issue(2);
    drain();

    // Held-off grant keeps the request stable; reset mid-wait clears outputs
    mode = 2'b10;
    exp_addr.push_back(32'h4);
    issue(1);
    repeat (3) @(negedge clk);
    check("held_instr", 64'(instr), 64'(mem_data(32'h4)));
    check("held_pc", 64'(pc), 64'h4);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_req", 64'(imem_req), 64'd1);
      check("wait_addr", 64'(imem_addr), 64'h8);
    end
    #3;
    rst = 1'b1;
    #1;
    check("arst_req", 64'(imem_req), 64'd0);
    check("arst_instr", 64'(instr), 64'(NOP));
    check("arst_pc", 64'(pc), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst  = 1'b0;
    mode = 2'b00;
    exp_addr.push_back(32'h0);
    exp_out.push_back({32'h0, mem_data(32'h0)});
    issue(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
